// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: opcode constants, the MEM-wait state
// enum and an rs2-usage decode helper. Also imported by the decode control unit.
package cpu_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // True when the opcode actually reads rs2; everything else (including
    // unknown opcodes) is treated as reading rs1 only.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        logic used;
        case (opcode)
            OP_RTYPE, OP_STORE, OP_BRANCH: used = 1'b1;
            OP_ITYPE, OP_LOAD:             used = 1'b0;
            default:                       used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory req/ack wait tracker. Raises freeze while a MEM-stage access
// is outstanding and sets a sticky error if the ack takes too long.
module mem_wait_fsm
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    input  logic mem_ack,
    output logic freeze,
    output logic mem_err
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX     = '1;
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(MEM_TIMEOUT);

    state_t               state;
    logic [TIMEOUT_W-1:0] wait_cnt;

    // State, wait counter and sticky error; waiting never ends on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ack) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        state <= RUN;
                    end else if (wait_cnt == TIMEOUT_VAL) begin
                        mem_err <= 1'b1;
                    end
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Freeze starts in the request cycle itself and covers the ack cycle.
    always_comb begin
        freeze = (state == MEM_WAIT) || (mem_req && !mem_ack);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller sitting beside ID: load-use bubble,
// taken-branch IF/ID flush and MEM req/ack freeze, with fixed priority
// freeze > load-use > branch flush.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush performance counters.
module hazard_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  ID_opcode_i,
    input  logic [4:0]  ID_rs1_i,
    input  logic [4:0]  ID_rs2_i,
    input  logic        EX_MemRead_i,
    input  logic [4:0]  EX_rd_i,
    input  logic        branch_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        NoOp_o,
    output logic        PCWrite_o,
    output logic        IF_ID_Write_o,
    output logic        IF_ID_Flush_o,
    output logic        freeze_o,
    output logic        mem_err_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_cnt_o
`endif
);

    logic mem_freeze;
    logic load_use;

    mem_wait_fsm #(
        .TIMEOUT_W  (TIMEOUT_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .mem_req(mem_req_i),
        .mem_ack(mem_ack_i),
        .freeze (mem_freeze),
        .mem_err(mem_err_o)
    );

    // Load in EX whose destination feeds a source the ID instruction reads; x0 is exempt.
    always_comb begin
        load_use = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                   ((EX_rd_i == ID_rs1_i) ||
                    (uses_rs2(ID_opcode_i) && (EX_rd_i == ID_rs2_i)));
    end

    // Priority mux; reset forces a bubble plus flush so nothing stale enters the pipe.
    always_comb begin
        NoOp_o        = 1'b0;
        PCWrite_o     = 1'b1;
        IF_ID_Write_o = 1'b1;
        IF_ID_Flush_o = 1'b0;
        freeze_o      = 1'b0;
        if (!rst_i) begin
            NoOp_o        = 1'b1;
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
            IF_ID_Flush_o = 1'b1;
        end else if (mem_freeze) begin
            freeze_o      = 1'b1;
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
        end else if (load_use) begin
            NoOp_o        = 1'b1;
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
        end else if (branch_taken_i) begin
            IF_ID_Flush_o = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running wrap-around counters of stall cycles and flush cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cycles_o <= 32'd0;
            flush_cnt_o    <= 32'd0;
        end else begin
            if (mem_freeze || load_use) begin
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end
            if (IF_ID_Flush_o) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;
    import cpu_pkg::*;

    localparam int TIMEOUT_W   = 4;
    localparam int MEM_TIMEOUT = 12;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [6:0] ID_opcode_i = 7'd0;
    logic [4:0] ID_rs1_i = 5'd0;
    logic [4:0] ID_rs2_i = 5'd0;
    logic       EX_MemRead_i = 1'b0;
    logic [4:0] EX_rd_i = 5'd0;
    logic       branch_taken_i = 1'b0;
    logic       mem_req_i = 1'b0;
    logic       mem_ack_i = 1'b0;
    logic       NoOp_o, PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, freeze_o, mem_err_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_o, flush_cnt_o;
`endif

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .TIMEOUT_W  (TIMEOUT_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .ID_opcode_i   (ID_opcode_i),
        .ID_rs1_i      (ID_rs1_i),
        .ID_rs2_i      (ID_rs2_i),
        .EX_MemRead_i  (EX_MemRead_i),
        .EX_rd_i       (EX_rd_i),
        .branch_taken_i(branch_taken_i),
        .mem_req_i     (mem_req_i),
        .mem_ack_i     (mem_ack_i),
        .NoOp_o        (NoOp_o),
        .PCWrite_o     (PCWrite_o),
        .IF_ID_Write_o (IF_ID_Write_o),
        .IF_ID_Flush_o (IF_ID_Flush_o),
        .freeze_o      (freeze_o),
        .mem_err_o     (mem_err_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles_o(stall_cycles_o),
        .flush_cnt_o   (flush_cnt_o)
`endif
    );

    typedef struct {
        logic        noop;
        logic        pcw;
        logic        ifw;
        logic        flush;
        logic        freeze;
        logic        err;
        logic [31:0] stall;
        logic [31:0] fcnt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: waiting flag, MEM_WAIT cycles elapsed, sticky error, counters.
    bit          m_wait = 1'b0;
    int          m_wcyc = 0;
    bit          m_err  = 1'b0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_fcnt  = 32'd0;

    function automatic bit reads_rs2(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs mid-cycle, predict the outputs, advance the model.
    task automatic step(input logic rst, input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic mr, input logic [4:0] rd,
                        input logic br, input logic req, input logic ack);
        exp_t e;
        bit   lu, frz;
        @(negedge clk);
        rst_i = rst; ID_opcode_i = op; ID_rs1_i = rs1; ID_rs2_i = rs2;
        EX_MemRead_i = mr; EX_rd_i = rd; branch_taken_i = br;
        mem_req_i = req; mem_ack_i = ack;
        if (!rst) begin
            m_wait = 1'b0; m_wcyc = 0; m_err = 1'b0; m_stall = 32'd0; m_fcnt = 32'd0;
        end
        lu  = mr && (rd != 5'd0) && ((rd == rs1) || (reads_rs2(op) && (rd == rs2)));
        frz = rst && (m_wait || (req && !ack));
        e.err = m_err; e.stall = m_stall; e.fcnt = m_fcnt;
        if (!rst)     begin e.noop = 1; e.pcw = 0; e.ifw = 0; e.flush = 1; e.freeze = 0; end
        else if (frz) begin e.noop = 0; e.pcw = 0; e.ifw = 0; e.flush = 0; e.freeze = 1; end
        else if (lu)  begin e.noop = 1; e.pcw = 0; e.ifw = 0; e.flush = 0; e.freeze = 0; end
        else if (br)  begin e.noop = 0; e.pcw = 1; e.ifw = 1; e.flush = 1; e.freeze = 0; end
        else          begin e.noop = 0; e.pcw = 1; e.ifw = 1; e.flush = 0; e.freeze = 0; end
        sb.push_back(e);
        if (rst) begin
            if (frz || lu) m_stall = m_stall + 32'd1;
            if (e.flush)   m_fcnt  = m_fcnt + 32'd1;
            if (m_wait) begin
                m_wcyc++;
                if (ack) m_wait = 1'b0;
                else if (m_wcyc == MEM_TIMEOUT + 1) m_err = 1'b1;
            end else if (req && !ack) begin
                m_wait = 1'b1;
                m_wcyc = 0;
            end
        end
    endtask

    task automatic idle(input logic rst, input int n);
        for (int i = 0; i < n; i++) step(rst, 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare the DUT against the oldest prediction, away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("NoOp",   {31'd0, NoOp_o},        {31'd0, e.noop});
                chk("PCWrite",{31'd0, PCWrite_o},     {31'd0, e.pcw});
                chk("IFIDWr", {31'd0, IF_ID_Write_o}, {31'd0, e.ifw});
                chk("Flush",  {31'd0, IF_ID_Flush_o}, {31'd0, e.flush});
                chk("freeze", {31'd0, freeze_o},      {31'd0, e.freeze});
                chk("mem_err",{31'd0, mem_err_o},     {31'd0, e.err});
`ifdef HAZARD_PERF_CNT_EN
                chk("stall_cycles", stall_cycles_o, e.stall);
                chk("flush_cnt",    flush_cnt_o,    e.fcnt);
`endif
            end
        end
    end

    initial begin
        logic [6:0] ops [6];
        logic [6:0] op;
        ops[0] = OP_RTYPE; ops[1] = OP_ITYPE; ops[2] = OP_LOAD;
        ops[3] = OP_STORE; ops[4] = OP_BRANCH; ops[5] = 7'b1101111;

        // Reset held, then idle
        idle(1'b0, 3);
        idle(1'b1, 2);

        // Load-use on rs1, then x0 and addi-rs2 non-hazards
        step(1'b1, OP_RTYPE, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_RTYPE, 5'd5, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_RTYPE, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_ITYPE, 5'd6, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);

        // Taken branch alone, then load-use on beq rs2 with branch taken
        step(1'b1, OP_BRANCH, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, OP_BRANCH, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1);

        // Memory wait of three cycles then ack; single-cycle access
        for (int i = 0; i < 3; i++) step(1'b1, 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        idle(1'b1, 2);

        // Timeout, then async reset in the middle of the wait
        for (int i = 0; i < 16; i++) step(1'b1, 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            op = ops[$urandom_range(0, 5)];
            step(($urandom_range(0, 63) != 0), op,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1));
        end
        idle(1'b1, 2);

        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
